// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: per-stage stall masks, exception flush
// with redirect PC, optional flush extension, stall watchdog and stall counter.
module pipe_ctrl #(
    parameter int unsigned STAGES       = 6,
    parameter int unsigned DW           = 32,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned STALL_LIMIT  = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq_i,
    input  logic [DW-1:0]     excepttype_i,
    input  logic [DW-1:0]     cp0_epc_i,
    input  logic [DW-1:0]     ebase_i,
    output logic [STAGES-1:0] stall_o,
    output logic              flush_o,
    output logic [DW-1:0]     new_pc_o,
    output logic              timeout_o,
    output logic [31:0]       stall_cnt_o
);

    localparam int unsigned CW  = 4;
    localparam int unsigned WDW = 32;

    typedef enum logic [0:0] {IDLE, EXT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   ext_cnt_q, ext_cnt_d;
    logic [DW-1:0]   vec_q, vec_d;
    logic [WDW-1:0]  wd_cnt_q, wd_cnt_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;
    logic [3:0]      hi;
    logic [STAGES-1:0] stall_mask;
    logic            exc, wd_expire, start;

    // Exception code to handler address; wraps modulo 2^DW.
    function automatic logic [DW-1:0] exc_vector(input logic [DW-1:0] code,
                                                 input logic [DW-1:0] base,
                                                 input logic [DW-1:0] epc);
        if (code == DW'(1))
            return base + DW'(32'h20);
        else if (code == DW'(8) || code == DW'(10) || code == DW'(12) || code == DW'(13))
            return base + DW'(32'h40);
        else if (code == DW'(14))
            return epc;
        else
            return base;
    endfunction

    // Highest requesting stage; an IF request also holds ID so the bubble stays there.
    always_comb begin
        hi = '0;
        for (int unsigned i = 1; i < STAGES - 1; i++) begin
            if (stallreq_i[i]) hi = 4'(i);
        end
        if (hi == 4'd1) hi = 4'd2;
        for (int unsigned k = 0; k < STAGES; k++) begin
            stall_mask[k] = (hi != 4'd0) && (4'(k) <= hi);
        end
    end

    assign exc       = (excepttype_i != '0);
    assign wd_expire = (STALL_LIMIT != 0) && (wd_cnt_q == WDW'(STALL_LIMIT)) && (hi != 4'd0);

    always_comb begin
        state_d     = state_q;
        ext_cnt_d   = ext_cnt_q;
        vec_d       = vec_q;
        stall_o     = '0;
        flush_o     = 1'b0;
        new_pc_o    = '0;
        timeout_o   = 1'b0;
        start       = 1'b0;

        if (exc) begin
            flush_o  = 1'b1;
            new_pc_o = exc_vector(excepttype_i, ebase_i, cp0_epc_i);
            start    = 1'b1;
        end else if (wd_expire) begin
            timeout_o = 1'b1;
            flush_o   = 1'b1;
            new_pc_o  = ebase_i + DW'(32'h40);
            start     = 1'b1;
        end else if (state_q == EXT) begin
            flush_o  = 1'b1;
            new_pc_o = vec_q;
            if (ext_cnt_q <= CW'(1)) begin
                state_d   = IDLE;
                ext_cnt_d = '0;
            end else begin
                ext_cnt_d = ext_cnt_q - CW'(1);
            end
        end else begin
            stall_o = stall_mask;
        end

        if (start) begin
            vec_d = new_pc_o;
            if (FLUSH_CYCLES > 1) begin
                state_d   = EXT;
                ext_cnt_d = CW'(FLUSH_CYCLES - 1);
            end else begin
                state_d   = IDLE;
                ext_cnt_d = '0;
            end
        end

        if (flush_o || !stall_o[0])
            wd_cnt_d = '0;
        else if (wd_cnt_q != '1)
            wd_cnt_d = wd_cnt_q + WDW'(1);
        else
            wd_cnt_d = wd_cnt_q;

        if (stall_o[0] && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 32'd1;
        else
            stall_cnt_d = stall_cnt_q;

        // Reset silences the pipeline controls immediately, even mid-flush.
        if (!rst) begin
            stall_o   = '0;
            flush_o   = 1'b0;
            new_pc_o  = '0;
            timeout_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            ext_cnt_q   <= '0;
            vec_q       <= '0;
            wd_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ext_cnt_q   <= ext_cnt_d;
            vec_q       <= vec_d;
            wd_cnt_q    <= wd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL provide parameter STAGES, default 6, number of pipeline stage-enable bits (bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB); legal range 5..8.
REQ-002 SHALL provide parameter DW, default 32, width of PC, EPC, EBASE and exception-type buses.
REQ-003 SHALL provide parameter FLUSH_CYCLES, default 1, total cycles flush_o stays high per accepted exception; legal range 1..15.
REQ-004 SHALL provide parameter STALL_LIMIT, default 1023, consecutive stalled cycles before watchdog timeout; 0 disables the watchdog.
REQ-005 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL provide port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL provide port stallreq_i  input  STAGES  stall request per stage; bit j from stage j; bits 0 and STAGES-1 ignored.
REQ-008 SHALL provide port excepttype_i  input  DW  exception code from MEM; zero = none.
REQ-009 SHALL provide port cp0_epc_i  input  DW  return address for ERET.
REQ-010 SHALL provide port ebase_i  input  DW  exception vector base.
REQ-011 SHALL provide port stall_o  output  STAGES  per-stage hold; 1 = stage holds.
REQ-012 SHALL provide port flush_o  output  1  pipeline flush.
REQ-013 SHALL provide port new_pc_o  output  DW  redirect PC, valid when flush_o=1, else 0.
REQ-014 SHALL provide port timeout_o  output  1  one-cycle pulse on watchdog expiry.
REQ-015 SHALL provide port stall_cnt_o  output  32  saturating count of cycles with stall_o[0]=1.

Function
REQ-016 SHALL evaluate priority in this order: exception, watchdog timeout, flush extension, stall, idle.
REQ-017 SHALL, on nonzero excepttype_i, drive flush_o=1, stall_o=0 and new_pc_o in the same cycle (combinational).
REQ-018 SHALL map vectors: 0x1 -> ebase_i+0x20; 0x8, 0xa, 0xc, 0xd -> ebase_i+0x40; 0xe -> cp0_epc_i; any other nonzero -> ebase_i; addition modulo 2^DW.
REQ-019 SHALL register the vector and hold flush_o=1 with new_pc_o=registered vector for FLUSH_CYCLES-1 further cycles (EXT state, down-counter).
REQ-020 SHALL, for a new nonzero excepttype_i during EXT, restart the extension with the new vector.
REQ-021 SHALL ignore stall requests during EXT and drive stall_o=0.
REQ-022 SHALL, absent exception/EXT, take the highest set stallreq_i bit j (1..STAGES-2) and drive stall_o[j:0]=1, other bits 0.
REQ-023 SHALL treat j=1 (IF request) as j=2 (stall_o[2:0]=1) so the IF bubble is held in ID.
REQ-024 SHALL drive stall_o=0, flush_o=0, new_pc_o=0 when no request, exception or EXT is active.
REQ-025 SHALL count consecutive cycles with stall_o[0]=1 in a watchdog counter, clearing it on any cycle with stall_o[0]=0 or flush_o=1.
REQ-026 SHALL, when STALL_LIMIT!=0 and the counter equals STALL_LIMIT while a stall is still requested, in that cycle pulse timeout_o=1, drive flush_o=1, stall_o=0, new_pc_o=ebase_i+0x40, enter EXT per REQ-019, and clear the counter.
REQ-027 SHALL give a simultaneous exception precedence over timeout; timeout_o stays 0 and the counter clears.
REQ-028 SHALL increment stall_cnt_o each cycle stall_o[0]=1, saturating at 0xFFFFFFFF.
REQ-029 SHALL keep FSM with states IDLE, EXT; IDLE->EXT on accepted exception/timeout when FLUSH_CYCLES>1; EXT->IDLE when counter reaches 0.

Reset
REQ-030 SHALL, while rst=0 at a rising edge, clear FSM to IDLE, EXT counter, registered vector, watchdog counter and stall_cnt_o to 0.
REQ-031 SHALL force stall_o=0, flush_o=0, new_pc_o=0, timeout_o=0 combinationally while rst=0, including mid-EXT or mid-stall.

Verification
REQ-032 SHALL cover: stallreq_i=6'b010000 (MEM) -> stall_o=6'b011111, flush_o=0; stallreq_i=6'b000010 -> stall_o=6'b000111.
REQ-033 SHALL cover: ebase_i=0x80000000, excepttype_i=0x8 with stallreq_i=6'b001000 -> same cycle flush_o=1, stall_o=0, new_pc_o=0x80000040.
REQ-034 SHALL cover: FLUSH_CYCLES=3, excepttype_i=0xe one cycle, cp0_epc_i=0x100 -> flush_o=1 for exactly 3 cycles, new_pc_o=0x100 throughout.
REQ-035 SHALL cover: STALL_LIMIT=4, stallreq_i held at EX -> stall_o=6'b001111 for 4 cycles, then 1-cycle timeout_o=1, flush_o=1, new_pc_o=ebase_i+0x40.
REQ-036 SHALL cover: rst=0 asserted during EXT with stall_cnt_o=7 -> next cycle all outputs 0, stall_cnt_o=0, FSM IDLE.
REQ-037 SHALL cover: excepttype_i=0x1 coinciding with watchdog expiry -> new_pc_o=ebase_i+0x20, timeout_o=0.
